// File: rtl/debounce_pkg.sv
// Shared constants and state encoding for the button debounce front end.
package debounce_pkg;

    // Default build-time parameters.
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 16;
    localparam int DEF_PCNT_W          = 8;

    // Debounce FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE         = 2'd0;
    localparam state_t CONFIRM_HIGH = 2'd1;
    localparam state_t HIGH         = 2'd2;
    localparam state_t CONFIRM_LOW  = 2'd3;

    // The debounced level is high once a press is committed, until release is committed.
    function automatic logic state_is_high(input state_t s);
        return (s == HIGH) || (s == CONFIRM_LOW);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the raw asynchronous input.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= d;
                end
            end else begin : g_next
                // Later stages give metastability time to resolve.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/debounce_toggle_gen.sv
// Turns a bouncy button into a single-cycle toggle request per debounced press.
module debounce_toggle_gen
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int PCNT_W          = DEF_PCNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_in,
    input  logic              enable,
    output logic              t_pulse,
    output logic              btn_stable,
    output logic [PCNT_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              btn_sync;
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              commit;
    logic              t_pulse_reg;
    logic              btn_stable_reg;
    logic [PCNT_W-1:0] press_count_reg;

    bit_synchronizer #(.STAGES(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // Next-state logic: a glitch in a confirm state always beats counter progress.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_sync) begin
                    state_next = CONFIRM_HIGH;
                    cnt_next   = CNT_ONE;
                end
            end
            CONFIRM_HIGH: begin
                if (!btn_sync) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                    commit     = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            HIGH: begin
                if (!btn_sync) begin
                    state_next = CONFIRM_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            default: begin
                if (btn_sync) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
        endcase
    end

    // State, counter and output registers; outputs follow the next state so they move with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            t_pulse_reg     <= 1'b0;
            btn_stable_reg  <= 1'b0;
            press_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            t_pulse_reg    <= commit & enable;
            btn_stable_reg <= state_is_high(state_next);
            if (commit && enable)
                press_count_reg <= press_count_reg + PCNT_W'(1);
        end
    end

    assign t_pulse     = t_pulse_reg;
    assign btn_stable  = btn_stable_reg;
    assign press_count = press_count_reg;

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// Randomized and directed bench for debounce_toggle_gen against a run-length reference model.
module tb_debounce_toggle_gen;
    import debounce_pkg::*;

    localparam int D    = DEF_DEBOUNCE_CYCLES;
    localparam int PW   = DEF_PCNT_W;
    localparam int LAT  = 2 + D;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_in = 1'b0;
    logic          enable = 1'b0;
    logic          t_pulse;
    logic          btn_stable;
    logic [PW-1:0] press_count;
    logic          q;

    int total = 0;
    int bad   = 0;

    // Reference model: two-sample delay line plus a run length of disagreeing samples.
    logic m_s0, m_s1, m_lvl, m_pulse;
    int   m_run, m_cnt;

    debounce_toggle_gen dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .enable      (enable),
        .t_pulse     (t_pulse),
        .btn_stable  (btn_stable),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    // Downstream toggle flop driven by t_pulse.
    always @(posedge clk or posedge reset) begin
        if (reset)        q <= 1'b0;
        else if (t_pulse) q <= ~q;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s0 = 0; m_s1 = 0; m_lvl = 0; m_pulse = 0; m_run = 0; m_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic tick(input logic b, input logic e);
        logic smp;
        btn_in = b;
        enable = e;
        @(posedge clk);
        smp  = m_s1;
        m_s1 = m_s0;
        m_s0 = b;
        m_pulse = 0;
        if (smp != m_lvl) begin
            m_run++;
            if (m_run == D) begin
                m_lvl = smp;
                m_run = 0;
                if (smp && e) begin
                    m_pulse = 1;
                    m_cnt = (m_cnt + 1) % (1 << PW);
                end
            end
        end else begin
            m_run = 0;
        end
        #1;
        check("t_pulse", 32'(t_pulse), 32'(m_pulse));
        check("btn_stable", 32'(btn_stable), 32'(m_lvl));
        check("press_count", 32'(press_count), m_cnt);
        $display("cyc btn=%0b en=%0b t_pulse=%0b stable=%0b count=%0d", b, e, t_pulse, btn_stable, press_count);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int pe, np, sb, seg, lvl, en;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_t_pulse", 32'(t_pulse), 0);
        check("rst_stable", 32'(btn_stable), 0);
        check("rst_count", 32'(press_count), 0);
        reset = 1'b0;

        // Idle after reset release.
        for (int i = 0; i < 20; i++) tick(0, 1);

        // Clean press: pulse and stable rise at edge 2+D.
        pe = 0; np = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1, 1);
            if (t_pulse) begin pe = i; np++; end
        end
        check("press_latency", pe, LAT);
        check("press_pulses", np, 1);
        check("press_count1", 32'(press_count), 1);
        // Release: stable falls at edge 2+D after the first low sample, no pulse.
        sb = 0; np = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(0, 1);
            if (!btn_stable && sb == 0) sb = i;
            if (t_pulse) np++;
        end
        check("release_latency", sb, LAT);
        check("release_pulses", np, 0);

        // Bounce then steady high: one pulse 2+D edges into the steady run.
        tick(1, 1); tick(0, 1); tick(1, 1); tick(1, 1); tick(0, 1);
        pe = 0; np = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1, 1);
            if (t_pulse) begin pe = i; np++; end
        end
        check("bounce_latency", pe, LAT);
        check("bounce_pulses", np, 1);
        for (int i = 0; i < 10; i++) tick(0, 1);

        // Short glitch of D-1 samples is rejected.
        np = 0;
        for (int i = 0; i < D - 1; i++) begin tick(1, 1); if (t_pulse) np++; end
        for (int i = 0; i < 10; i++) begin tick(0, 1); if (t_pulse) np++; end
        check("glitch_pulses", np, 0);
        check("glitch_stable", 32'(btn_stable), 0);

        // Press with enable=0, then with enable=1.
        np = 0;
        for (int i = 0; i < 10; i++) begin tick(1, 0); if (t_pulse) np++; end
        check("noen_pulses", np, 0);
        check("noen_stable", 32'(btn_stable), 1);
        check("noen_count", 32'(press_count), 2);
        for (int i = 0; i < 10; i++) tick(0, 0);
        for (int i = 0; i < 10; i++) tick(1, 1);
        check("en_count", 32'(press_count), 3);
        for (int i = 0; i < 10; i++) tick(0, 1);

        // Randomized segments checked cycle by cycle against the model.
        for (int s = 0; s < 300; s++) begin
            seg = $urandom_range(1, 8);
            lvl = $urandom_range(0, 1);
            en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            for (int i = 0; i < seg; i++) tick(lvl[0], en[0]);
        end

        // 256 clean presses wrap the counter and restore the toggle flop.
        do_reset();
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < D + 3; i++) tick(1, 1);
            for (int i = 0; i < D + 3; i++) tick(0, 1);
        end
        check("wrap_count", 32'(press_count), 0);
        check("wrap_q", 32'(q), 0);

        // Asynchronous reset while HIGH clears outputs without waiting for an edge.
        for (int i = 0; i < 10; i++) tick(1, 1);
        #2 reset = 1'b1;
        #1;
        check("async_stable", 32'(btn_stable), 0);
        check("async_count", 32'(press_count), 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) tick(0, 1);

        // Reset in CONFIRM_HIGH with the button held: one new pulse after release.
        for (int i = 0; i < 3; i++) tick(1, 1);
        #1 reset = 1'b1;
        model_clear();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("hold_rst_pulse", 32'(t_pulse), 0);
            check("hold_rst_stable", 32'(btn_stable), 0);
        end
        reset = 1'b0;
        pe = 0; np = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1, 1);
            if (t_pulse) begin pe = i; np++; end
        end
        check("post_rst_latency", pe, LAT);
        check("post_rst_pulses", np, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
